// File: rtl/rx_word_assembler_pkg.sv
// rx_word_assembler_pkg: shared FSM states and default timing constants for the receive path
package rx_word_assembler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 12_200_000;

endpackage

// File: rtl/rx_word_assembler_idle_timer.sv
// idle_timer: counts enabled cycles since the last clear and flags when the idle budget is used up
module idle_timer
    import rx_word_assembler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/rx_word_assembler.sv
// rx_word_assembler: packs UART bytes little-endian into scalar or MAX_ADDR-word vector frames
module rx_word_assembler
    import rx_word_assembler_pkg::*;
#(
    parameter int MAX_ADDR       = 1024,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_ready,
    input  logic                        start,
    input  logic                        out_mode,
    input  logic [1:0]                  max_pck,
    output logic [31:0]                 word_out,
    output logic [$clog2(MAX_ADDR)-1:0] w_addr,
    output logic                        w_en,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err
);

    localparam int AW = $clog2(MAX_ADDR);

    state_t          state;
    logic            mode;
    logic [1:0]      pck;
    logic [1:0]      byte_idx;
    logic [31:0]     shift;
    logic [31:0]     merged;
    logic [AW-1:0]   addr;
    logic            last;
    logic            expired;

    assign busy = state != IDLE;
    assign last = mode || addr == AW'(MAX_ADDR - 1);

    always_comb begin
        merged = shift;
        merged[{byte_idx, 3'b000} +: 8] = rx_data;
    end

    idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE || (rx_ready && (state == COLLECT || state == WRITE))),
        .enable (state == COLLECT && !rx_ready),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode        <= 1'b0;
            pck         <= 2'd0;
            byte_idx    <= 2'd0;
            shift       <= '0;
            addr        <= '0;
            word_out    <= '0;
            w_addr      <= '0;
            w_en        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            w_en        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mode     <= out_mode;
                    pck      <= max_pck;
                    shift    <= '0;
                    byte_idx <= 2'd0;
                    addr     <= '0;
                    state    <= COLLECT;
                end
                COLLECT: if (rx_ready) begin
                    shift    <= merged;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == pck) begin
                        word_out <= merged;
                        w_addr   <= addr;
                        w_en     <= 1'b1;
                        state    <= WRITE;
                    end
                end else if (expired) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end
                WRITE: if (last) begin
                    state <= DONE;
                end else begin
                    // a byte landing here opens the next word; with one-byte words it closes it too
                    addr     <= addr + 1'b1;
                    shift    <= rx_ready ? {24'h0, rx_data} : 32'h0;
                    byte_idx <= rx_ready ? 2'd1 : 2'd0;
                    state    <= COLLECT;
                    if (rx_ready && pck == 2'd0) begin
                        word_out <= {24'h0, rx_data};
                        w_addr   <= addr + 1'b1;
                        w_en     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_word_assembler.sv
// tb_rx_word_assembler: directed frames checked every cycle against a byte-stream model of the framing rules
module tb_rx_word_assembler;

    localparam int MAX = 1024;
    localparam int TO  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_ready = 1'b0;
    logic        start = 1'b0;
    logic        out_mode = 1'b0;
    logic [1:0]  max_pck = 2'd0;
    logic [31:0] word_out;
    logic [9:0]  w_addr;
    logic        w_en;
    logic        busy;
    logic        done;
    logic        timeout_err;

    rx_word_assembler #(.MAX_ADDR(MAX), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .start      (start),
        .out_mode   (out_mode),
        .max_pck    (max_pck),
        .word_out   (word_out),
        .w_addr     (w_addr),
        .w_en       (w_en),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [31:0] w;
        int          a;
    } wexp_t;

    wexp_t       wq[$];
    int          dq[$];
    int          tq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          wen_cnt = 0;
    int          done_cnt = 0;
    int          to_cnt = 0;
    int          wen_cyc = 0;
    int          done_cyc = 0;
    logic        armed = 1'b0;
    logic [31:0] hold_w = 32'h0;
    int          hold_a = 0;
    logic        m_active = 1'b0;
    logic        m_closing = 1'b0;
    logic        m_mode = 1'b0;
    int          m_pck = 0;
    int          m_n = 0;
    int          m_addr = 0;
    int          m_idle_from = 0;
    int          m_deadline = 0;
    logic [31:0] m_cur = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // what the DUT must do for the inputs sampled at rising edge k
    task automatic model_edge(input int k);
        if (rst) begin
            m_active = 1'b0;
            m_closing = 1'b0;
            m_idle_from = k;
            wq.delete();
            dq.delete();
            tq.delete();
            hold_w = 32'h0;
            hold_a = 0;
            armed = 1'b1;
            return;
        end
        if (m_active && m_closing && k - 1 >= m_idle_from)
            m_active = 1'b0;
        if (!m_active) begin
            if (start && k - 1 >= m_idle_from) begin
                m_active = 1'b1;
                m_closing = 1'b0;
                m_mode = out_mode;
                m_pck = int'(max_pck);
                m_n = 0;
                m_cur = 32'h0;
                m_addr = 0;
                m_deadline = k + TO;
            end
            return;
        end
        if (m_closing)
            return;
        if (rx_ready) begin
            m_cur[8*m_n +: 8] = rx_data;
            m_n++;
            m_deadline = k + TO;
            if (m_n == m_pck + 1) begin
                wq.push_back('{k, m_cur, m_addr});
                m_cur = 32'h0;
                m_n = 0;
                if (m_mode || m_addr == MAX - 1) begin
                    m_closing = 1'b1;
                    m_idle_from = k + 2;
                    dq.push_back(k + 2);
                end else begin
                    m_addr++;
                    m_deadline = k + TO + 1;
                end
            end
        end else if (k == m_deadline) begin
            tq.push_back(k);
            m_active = 1'b0;
            m_idle_from = k;
        end
    endtask

    initial forever begin
        logic ew, ed, et;
        @(posedge clk);
        #1;
        if (armed) begin
            while (wq.size() > 0 && wq[0].c < cyc) void'(wq.pop_front());
            while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
            while (tq.size() > 0 && tq[0] < cyc) void'(tq.pop_front());
            ew = wq.size() > 0 && wq[0].c == cyc;
            ed = dq.size() > 0 && dq[0] == cyc;
            et = tq.size() > 0 && tq[0] == cyc;
            chk("w_en", 32'(w_en), 32'(ew));
            if (ew) begin
                hold_w = wq[0].w;
                hold_a = wq[0].a;
                void'(wq.pop_front());
            end
            chk("word_out", word_out, hold_w);
            chk("w_addr", 32'(w_addr), 32'(hold_a));
            chk("done", 32'(done), 32'(ed));
            chk("timeout_err", 32'(timeout_err), 32'(et));
            chk("busy", 32'(busy), 32'(m_active && !(m_closing && cyc >= m_idle_from)));
            if (ed) void'(dq.pop_front());
            if (et) void'(tq.pop_front());
        end
        if (w_en === 1'b1) begin
            wen_cnt++;
            wen_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (timeout_err === 1'b1) to_cnt++;
    end

    task automatic drive();
        model_edge(cyc + 1);
        @(negedge clk);
        rx_ready = 1'b0;
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) drive();
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_ready = 1'b1;
        drive();
    endtask

    task automatic go(input logic om, input logic [1:0] mp);
        out_mode = om;
        max_pck = mp;
        start = 1'b1;
        drive();
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            rst = 1'b1;
            drive();
        end
    endtask

    initial begin
        int w0, d0, t0;
        @(negedge clk);
        do_reset(2);
        chk("rst_word_out", word_out, 32'h0);
        chk("rst_w_addr", 32'(w_addr), 32'h0);
        chk("rst_w_en", 32'(w_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);

        // scalar word, 4 bytes
        go(1'b1, 2'd3);
        put(8'h78);
        put(8'h56);
        put(8'h34);
        put(8'h12);
        tick(4);
        chk("t1_word", word_out, 32'h12345678);
        chk("t1_addr", 32'(w_addr), 32'h0);
        chk("t1_wen_count", 32'(wen_cnt), 32'd1);
        chk("t1_done_count", 32'(done_cnt), 32'd1);
        chk("t1_done_gap", 32'(done_cyc - wen_cyc), 32'd2);

        // full vector, 2-byte words, bytes back to back
        w0 = wen_cnt;
        d0 = done_cnt;
        go(1'b0, 2'd1);
        for (int i = 0; i < 2 * MAX; i++) put(8'(i));
        tick(4);
        chk("t2_wen_count", 32'(wen_cnt - w0), 32'(MAX));
        chk("t2_last_addr", 32'(w_addr), 32'd1023);
        chk("t2_last_word", word_out, 32'h0000FFFE);
        chk("t2_done_count", 32'(done_cnt - d0), 32'd1);

        // single-byte word; byte before start is ignored
        put(8'hEE);
        go(1'b1, 2'd0);
        put(8'hAB);
        tick(4);
        chk("t3_word", word_out, 32'h000000AB);

        // timeout on a partial word, then a fresh frame
        w0 = wen_cnt;
        t0 = to_cnt;
        go(1'b0, 2'd3);
        put(8'hC1);
        put(8'hC2);
        tick(TO + 4);
        chk("t4_timeout_count", 32'(to_cnt - t0), 32'd1);
        chk("t4_no_wen", 32'(wen_cnt - w0), 32'd0);
        chk("t4_busy_low", 32'(busy), 32'h0);
        go(1'b1, 2'd0);
        put(8'h5A);
        tick(4);
        chk("t4_restart_word", word_out, 32'h0000005A);

        // byte during the write cycle, start while busy, then reset mid-frame
        w0 = wen_cnt;
        d0 = done_cnt;
        t0 = to_cnt;
        go(1'b0, 2'd1);
        put(8'h11);
        go(1'b1, 2'd0);
        put(8'h22);
        put(8'h33);
        put(8'h44);
        go(1'b1, 2'd3);
        put(8'h55);
        put(8'h66);
        tick(2);
        chk("t5_wen_count", 32'(wen_cnt - w0), 32'd3);
        chk("t5_word", word_out, 32'h00006655);
        chk("t5_addr", 32'(w_addr), 32'd2);
        do_reset(2);
        chk("t6_word_out", word_out, 32'h0);
        chk("t6_w_addr", 32'(w_addr), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        tick(3);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t6_no_timeout", 32'(to_cnt - t0), 32'd0);
        go(1'b1, 2'd2);
        put(8'h01);
        put(8'h02);
        put(8'h03);
        tick(4);
        chk("t6_word", word_out, 32'h00030201);
        chk("t6_addr", 32'(w_addr), 32'h0);
        chk("t6_done_count", 32'(done_cnt - d0), 32'd1);

        tick(2);
        chk("pending_expectations", 32'(wq.size() + dq.size() + tq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
